// File: rtl/cast_injector.sv
// cast_injector: generates a stream of tagged words into a PE cast input.
// Each run sends NUM_PKTS words. There is an optional start delay and an
// optional idle gap after each accepted word. Every word carries the node tag
// {x, y} and its sequence number.
// Optional feature: define CAST_INJECTOR_STALL_EN to build the back-pressure
// (stall) cycle counter. Without it, stall_cnt_o is tied to zero.

`ifndef DW
`define DW 32
`endif

module cast_injector #(
  parameter int x           = 0,
  parameter int y           = 0,
  parameter int NUM_PKTS    = 10000,
  parameter int START_DELAY = 0,
  parameter int GAP         = 0
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start_i,
  output logic [`DW-1:0] cast_data_o,
  output logic           cast_valid_o,
  input  logic           cast_ready_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [31:0]    sent_cnt_o,
  output logic [31:0]    stall_cnt_o
);

  // Width of the sequence-number field below the two 4-bit tags.
  localparam int SEQ_W = `DW - 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DELAY = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;
  localparam logic [31:0] LAST_IDX   = (NUM_PKTS > 0)    ? 32'(NUM_PKTS - 1)    : 32'd0;
  localparam logic [31:0] DELAY_LOAD = (START_DELAY > 0) ? 32'(START_DELAY - 1) : 32'd0;
  localparam logic [31:0] GAP_LOAD   = (GAP > 0)         ? 32'(GAP - 1)         : 32'd0;
  localparam logic [3:0]  X_TAG      = 4'(x);
  localparam logic [3:0]  Y_TAG      = 4'(y);

  logic [2:0]     state_q, state_d;
  logic [31:0]    delay_cnt_q, delay_cnt_d;
  logic [31:0]    gap_cnt_q, gap_cnt_d;
  logic [31:0]    sent_cnt_q, sent_cnt_d;
  logic           valid_q, valid_d;
  logic [`DW-1:0] data_q, data_d;
  logic [SEQ_W-1:0] seq_w;
  logic           handshake;
  logic           run_start;

  assign handshake = valid_q & cast_ready_i;
  // start_i only matters when no run is in flight.
  assign run_start = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Fit the 32-bit word counter into the sequence field (zero-extend or truncate).
  generate
    if (SEQ_W > 32) begin : g_seq_ext
      assign seq_w = {{(SEQ_W - 32){1'b0}}, sent_cnt_d};
    end else if (SEQ_W == 32) begin : g_seq_eq
      assign seq_w = sent_cnt_d;
    end else begin : g_seq_trunc
      assign seq_w = sent_cnt_d[SEQ_W-1:0];
    end
  endgenerate

  // Next-state logic. valid and data are computed one cycle ahead, so the
  // outputs are registered and do not depend combinationally on ready.
  always_comb begin
    state_d     = state_q;
    delay_cnt_d = delay_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    sent_cnt_d  = sent_cnt_q;
    valid_d     = valid_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        valid_d = 1'b0;
        if (run_start) begin
          sent_cnt_d = '0;
          if (NUM_PKTS == 0) begin
            state_d = S_DONE;
          end else if (START_DELAY > 0) begin
            state_d     = S_DELAY;
            delay_cnt_d = DELAY_LOAD;
          end else begin
            state_d = S_SEND;
            valid_d = 1'b1;
          end
        end
      end
      S_DELAY: begin
        if (delay_cnt_q == 32'd0) begin
          state_d = S_SEND;
          valid_d = 1'b1;
        end else begin
          delay_cnt_d = delay_cnt_q - 32'd1;
        end
      end
      S_SEND: begin
        // Without a handshake everything holds, so the word stays stable.
        if (handshake) begin
          if (sent_cnt_q != CNT_MAX) begin
            sent_cnt_d = sent_cnt_q + 32'd1;
          end
          if (sent_cnt_q == LAST_IDX) begin
            state_d = S_DONE;
            valid_d = 1'b0;
          end else if (GAP > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
            valid_d   = 1'b0;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 32'd0) begin
          state_d = S_SEND;
          valid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
    data_d = valid_d ? {X_TAG, Y_TAG, seq_w} : '0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      delay_cnt_q <= '0;
      gap_cnt_q   <= '0;
      sent_cnt_q  <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      delay_cnt_q <= delay_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      sent_cnt_q  <= sent_cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
    end
  end

`ifdef CAST_INJECTOR_STALL_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where a word is offered but not taken, saturating.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (run_start) begin
      stall_cnt_d = '0;
    end else if (valid_q && !cast_ready_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

  assign cast_data_o  = data_q;
  assign cast_valid_o = valid_q;
  assign sent_cnt_o   = sent_cnt_q;
  assign busy_o       = (state_q == S_DELAY) || (state_q == S_SEND) || (state_q == S_GAP);
  assign done_o       = (state_q == S_DONE);

endmodule

// File: tb/tb_cast_injector.sv
// Directed testbench for cast_injector: three instances cover the basic run,
// back-pressure, reset mid-run, delay/gap timing and the zero-length run.

`ifndef DW
`define DW 32
`endif

module tb_cast_injector;

  logic clk = 1'b0;
  logic rstn;
  logic start_a, start_b, start_c;
  logic ready_a, ready_b, ready_c;
  logic [`DW-1:0] data_a, data_b, data_c;
  logic valid_a, valid_b, valid_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic [31:0] sent_a, sent_b, sent_c;
  logic [31:0] stall_a, stall_b, stall_c;

  int   n_checks = 0;
  int   n_errors = 0;
  int   k;
  logic exp_v;
  logic hs;

`ifdef CAST_INJECTOR_STALL_EN
  localparam logic [31:0] STALL_EXP = 32'd4;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
`endif

  always #5 clk = ~clk;

  cast_injector #(.x(5), .y(2), .NUM_PKTS(4)) u_dut_a (
    .clk(clk), .rstn(rstn), .start_i(start_a),
    .cast_data_o(data_a), .cast_valid_o(valid_a), .cast_ready_i(ready_a),
    .busy_o(busy_a), .done_o(done_a), .sent_cnt_o(sent_a), .stall_cnt_o(stall_a)
  );

  cast_injector #(.x(1), .y(3), .NUM_PKTS(3), .START_DELAY(3), .GAP(2)) u_dut_b (
    .clk(clk), .rstn(rstn), .start_i(start_b),
    .cast_data_o(data_b), .cast_valid_o(valid_b), .cast_ready_i(ready_b),
    .busy_o(busy_b), .done_o(done_b), .sent_cnt_o(sent_b), .stall_cnt_o(stall_b)
  );

  cast_injector #(.NUM_PKTS(0)) u_dut_c (
    .clk(clk), .rstn(rstn), .start_i(start_c),
    .cast_data_o(data_c), .cast_valid_o(valid_c), .cast_ready_i(ready_c),
    .busy_o(busy_c), .done_o(done_c), .sent_cnt_o(sent_c), .stall_cnt_o(stall_c)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [`DW-1:0] word(input logic [3:0] xt, input logic [3:0] yt, input int idx);
    return {xt, yt, (`DW-8)'(idx)};
  endfunction

  initial begin
    rstn    = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_valid", 64'(valid_a), 64'd0);
    check("rst_data",  64'(data_a),  64'd0);
    check("rst_busy",  64'(busy_a),  64'd0);
    check("rst_done",  64'(done_a),  64'd0);
    check("rst_sent",  64'(sent_a),  64'd0);
    check("rst_stall", 64'(stall_a), 64'd0);
    check("rst_b_busy", 64'(busy_b), 64'd0);
    rstn = 1'b1;
    tick();
    check("idle_valid", 64'(valid_a), 64'd0);

    // Four words back to back, ready held high
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("t1_tag", 64'(data_a[`DW-1 -: 8]), 64'h52);
    check("t1_seq0", 64'(data_a[`DW-9:0]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("t1_valid", 64'(valid_a), 64'd1);
      check("t1_data",  64'(data_a),  64'(word(4'd5, 4'd2, i)));
      check("t1_busy",  64'(busy_a),  64'd1);
      $display("a run1 word %0d data 0x%0h", i, data_a);
      tick();
    end
    check("t1_valid_end", 64'(valid_a), 64'd0);
    check("t1_done",      64'(done_a),  64'd1);
    check("t1_sent",      64'(sent_a),  64'd4);
    check("t1_busy_end",  64'(busy_a),  64'd0);
    repeat (3) tick();
    check("t1_done_hold", 64'(done_a), 64'd1);

    // Back-pressure for cycles 2-5, plus a start pulse during SEND
    k = 0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      ready_a = !((c >= 2) && (c <= 5));
      start_a = (c == 3);
      exp_v   = (k < 4);
      check("t2_valid", 64'(valid_a), 64'(exp_v));
      if (exp_v) check("t2_data", 64'(data_a), 64'(word(4'd5, 4'd2, k)));
      if (c == 6) check("t2_stall_mid", 64'(stall_a), 64'(STALL_EXP));
      hs = exp_v && ready_a;
      if (hs) $display("a run2 word %0d data 0x%0h", k, data_a);
      tick();
      if (hs) k++;
    end
    start_a = 1'b0; ready_a = 1'b1;
    check("t2_done",  64'(done_a),  64'd1);
    check("t2_sent",  64'(sent_a),  64'd4);
    check("t2_stall", 64'(stall_a), 64'(STALL_EXP));

    // Reset while word 2 is on offer, then restart
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); tick();
    check("t3_word2", 64'(data_a), 64'(word(4'd5, 4'd2, 2)));
    rstn = 1'b0; tick();
    check("t3_rst_valid", 64'(valid_a), 64'd0);
    check("t3_rst_data",  64'(data_a),  64'd0);
    check("t3_rst_busy",  64'(busy_a),  64'd0);
    check("t3_rst_done",  64'(done_a),  64'd0);
    check("t3_rst_sent",  64'(sent_a),  64'd0);
    check("t3_rst_stall", 64'(stall_a), 64'd0);
    rstn = 1'b1; repeat (2) tick();
    check("t3_idle_valid", 64'(valid_a), 64'd0);
    check("t3_idle_busy",  64'(busy_a),  64'd0);
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("t3_restart_valid", 64'(valid_a), 64'd1);
    check("t3_restart_data",  64'(data_a),  64'(word(4'd5, 4'd2, 0)));
    check("t3_restart_sent",  64'(sent_a),  64'd0);
    repeat (4) tick();
    check("t3_done", 64'(done_a), 64'd1);
    check("t3_sent", 64'(sent_a), 64'd4);

    // Start delay 3, gap 2: valids at cycles 4, 7, 10; done from cycle 11
    k = 0;
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      exp_v = (c == 4) || (c == 7) || (c == 10);
      check("tb_valid", 64'(valid_b), 64'(exp_v));
      if (exp_v) begin
        check("tb_data", 64'(data_b), 64'(word(4'd1, 4'd3, k)));
        $display("b word %0d data 0x%0h cycle %0d", k, data_b, c);
        k++;
      end
      check("tb_busy", 64'(busy_b), 64'(c <= 10));
      check("tb_done", 64'(done_b), 64'(c >= 11));
      tick();
    end
    check("tb_sent",  64'(sent_b),  64'd3);
    check("tb_stall", 64'(stall_b), 64'd0);

    // Zero-length run
    start_c = 1'b1; tick(); start_c = 1'b0;
    check("tc_done",  64'(done_c),  64'd1);
    check("tc_valid", 64'(valid_c), 64'd0);
    check("tc_busy",  64'(busy_c),  64'd0);
    check("tc_sent",  64'(sent_c),  64'd0);
    tick();
    check("tc_valid2", 64'(valid_c), 64'd0);
    check("tc_done2",  64'(done_c),  64'd1);
    check("tc_data",   64'(data_c),  64'd0);
    check("tc_stall",  64'(stall_c), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cast_injector.md
CAST_INJECTOR -- requirements
Module: cast_injector

Interface
REQ-001 SHALL have parameter x, default 0, node column; tag field.
REQ-002 SHALL have parameter y, default 0, node row; tag field.
REQ-003 SHALL have parameter NUM_PKTS, default 10000, words per run.
REQ-004 SHALL have parameter START_DELAY, default 0, idle cycles between start and first valid.
REQ-005 SHALL have parameter GAP, default 0, idle cycles after each accepted word.
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-008 SHALL have port start_i  input  1  run request, sampled in IDLE and DONE only.
REQ-009 SHALL have port cast_data_o  output  `DW  injected word, drives a PE cast input.
REQ-010 SHALL have port cast_valid_o  output  1  word valid.
REQ-011 SHALL have port cast_ready_i  input  1  downstream ready.
REQ-012 SHALL have port busy_o  output  1  high in DELAY, SEND, GAP.
REQ-013 SHALL have port done_o  output  1  high in DONE.
REQ-014 SHALL have port sent_cnt_o  output  32  accepted words this run.
REQ-015 SHALL have port stall_cnt_o  output  32  cycles with valid high and ready low this run.

Function
REQ-016 SHALL implement FSM states IDLE, DELAY, SEND, GAP, DONE.
REQ-017 From IDLE or DONE, when start_i=1: SHALL clear sent_cnt_o and stall_cnt_o; next state is DELAY if START_DELAY>0, else SEND; if NUM_PKTS=0, next state is DONE.
REQ-018 DELAY SHALL last exactly START_DELAY cycles, then go to SEND; first valid is cycle t+1+START_DELAY for start sampled at edge t.
REQ-019 cast_valid_o SHALL be high only in SEND; it is registered, with no combinational path from cast_ready_i.
REQ-020 On handshake (valid & ready), sent_cnt_o SHALL increment.
REQ-021 On that handshake, if it is word NUM_PKTS-1, next state is DONE; else if GAP>0, next state is GAP; else stay in SEND.
REQ-022 With GAP=0 and ready held high, throughput SHALL be one word per cycle with no bubbles.
REQ-023 GAP SHALL last exactly GAP cycles with valid low, then return to SEND.
REQ-024 While valid is high and ready low, cast_data_o and cast_valid_o SHALL hold stable; valid SHALL never drop without a handshake.
REQ-025 cast_data_o SHALL be: [`DW-1:`DW-4]=x[3:0], [`DW-5:`DW-8]=y[3:0], [`DW-9:0]=sent_cnt_o zero-extended or truncated; `DW>=24 is required.
REQ-026 start_i SHALL be ignored in DELAY, SEND and GAP.
REQ-027 done_o SHALL stay high in DONE until start_i restarts a run.
REQ-028 Both counters SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-029 With rstn=0 at an edge: state SHALL be IDLE, cast_valid_o=0, cast_data_o=0, busy_o=0, done_o=0, sent_cnt_o=0, stall_cnt_o=0, internal delay and gap counters 0.
REQ-030 Reset mid-run SHALL abort immediately; no further valid until a new start_i after rstn=1.

Configuration
REQ-031 With macro CAST_INJECTOR_STALL_EN defined: stall_cnt_o SHALL count per REQ-015 and saturate per REQ-028.
REQ-032 Without CAST_INJECTOR_STALL_EN: stall_cnt_o SHALL be constant 0 and no stall counter register is built; all other behaviour is identical.

Verification
REQ-033 NUM_PKTS=4, GAP=0, START_DELAY=0, ready=1, start at edge 0 -> valid cycles 1-4, low bits 0,1,2,3, done_o=1 from cycle 5, sent_cnt_o=4.
REQ-034 START_DELAY=3, GAP=2, NUM_PKTS=3, ready=1 -> first valid at cycle 4, valids at cycles 4, 7, 10, done at cycle 11.
REQ-035 ready low for cycles 2-5 during a run with NUM_PKTS=4 -> data frozen; with STALL_EN, stall_cnt_o=4; without it, 0; total sent 4.
REQ-036 NUM_PKTS=0, start -> done_o=1 next cycle, no valid.
REQ-037 x=5, y=2, `DW=32 -> first word 32'h5200_0000.
REQ-038 rstn low during SEND at word 2, then restart with start_i -> IDLE after reset, counters 0, new run restarts at sequence 0.
